bin2bcd_seq: RTL and testbench

Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock.
It generalises the team's fixed-width sum-of-powers converter in three ways: arbitrary binary width and digit count, a valid/ready handshake on both sides, and a sticky overflow flag plus a significant-digit count.
It sits between binary datapaths (counters, ADC results) and 7-segment or display drivers.

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bin2bcd_seq_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 171 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : converter FSM states
//   min_digits : smallest digit count that holds any unsigned value of
//                'width' bits without overflow, i.e. ceil(width * log10(2))
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Fixed-point log10(2) = 0.30103, rounded up.
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One BCD digit correction step of the double-dabble algorithm.
// Ports:
//   digit_i : current 4-bit BCD digit
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i unchanged
module bcd_add3_digit (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high; waits for in_valid, then loads the shift register
// SHIFT | busy; one add-3 + shift per cycle, BIN_WIDTH cycles in total
// DONE  | out_valid high, results stable until out_ready
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, binary_in sampled on accept
//   out_valid/out_ready : output handshake for bcd_out/overflow/digit_count
//   bcd_out           : packed BCD digits, digit 0 in bits [3:0]
//   overflow          : value exceeded 10^NUM_DIGITS-1 (bcd_out is modulo)
//   digit_count       : index+1 of highest non-zero digit, 1 for zero
//   busy              : conversion in progress
//   neg_out           : sign of the input (only with SIGNED_INPUT_EN)
//
// Build option: define SIGNED_INPUT_EN to treat binary_in as two's
// complement; the magnitude is converted and the sign appears on neg_out.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int  BIN_WIDTH  = 8,
    parameter int  NUM_DIGITS = 3,
    localparam int DCNT_W     = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    binary_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow,
    output logic [DCNT_W-1:0]       digit_count,
    output logic                    busy
`ifdef SIGNED_INPUT_EN
    ,
    output logic                    neg_out
`endif
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int ACC_W = 4 * NUM_DIGITS;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shreg_q, sh_next, load_val;
    logic [ACC_W-1:0]     accum_q, adj, acc_next;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_acc_q, ovf_next;
    logic [ACC_W-1:0]     bcd_q;
    logic                 ovf_q;
    logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
    logic                 last_shift;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_i (accum_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // The corrected top digit's MSB leaves the accumulator on this shift.
    assign {acc_next, sh_next} = {adj[ACC_W-2:0], shreg_q, 1'b0};
    assign ovf_next            = ovf_acc_q | adj[ACC_W-1];
    assign last_shift          = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

`ifdef SIGNED_INPUT_EN
    logic sign_q;
    logic neg_q;
    // Negating the most negative value wraps to 2^(BIN_WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    assign load_val = binary_in[BIN_WIDTH-1] ? -binary_in : binary_in;
    assign neg_out  = neg_q;
`else
    assign load_val = binary_in;
`endif

    always_comb begin
        dcnt_d = DCNT_W'(1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_next[4*i +: 4] != 4'd0) begin
                dcnt_d = DCNT_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Results are copied to the output registers only on the final shift,
    // so bcd_out/overflow/digit_count never show a partial conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            accum_q   <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            dcnt_q    <= DCNT_W'(1);
`ifdef SIGNED_INPUT_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q   <= load_val;
                        accum_q   <= '0;
                        ovf_acc_q <= 1'b0;
                        cnt_q     <= CNT_W'(BIN_WIDTH);
`ifdef SIGNED_INPUT_EN
                        sign_q    <= binary_in[BIN_WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    shreg_q   <= sh_next;
                    accum_q   <= acc_next;
                    ovf_acc_q <= ovf_next;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (last_shift) begin
                        bcd_q  <= acc_next;
                        ovf_q  <= ovf_next;
                        dcnt_q <= dcnt_d;
`ifdef SIGNED_INPUT_EN
                        neg_q  <= sign_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out     = bcd_q;
    assign overflow    = ovf_q;
    assign digit_count = dcnt_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic [1:0]  dcnt;
        logic        neg;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid_t;
    logic        out_ready_t;
    logic        sel;          // 0: 8-bit DUT, 1: 10-bit DUT
    logic [9:0]  bin_t;

    logic        in_ready8, out_valid8, ovf8, busy8;
    logic [11:0] bcd8;
    logic [1:0]  dcnt8;
    logic        in_ready10, out_valid10, ovf10, busy10;
    logic [11:0] bcd10;
    logic [1:0]  dcnt10;
    logic        neg8, neg10;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    bin2bcd_seq #(.BIN_WIDTH(8), .NUM_DIGITS(min_digits(8))) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_t & ~sel),
        .in_ready    (in_ready8),
        .binary_in   (bin_t[7:0]),
        .out_valid   (out_valid8),
        .out_ready   (out_ready_t & ~sel),
        .bcd_out     (bcd8),
        .overflow    (ovf8),
        .digit_count (dcnt8),
        .busy        (busy8)
`ifdef SIGNED_INPUT_EN
        ,
        .neg_out     (neg8)
`endif
    );

    bin2bcd_seq #(.BIN_WIDTH(10), .NUM_DIGITS(3)) u_dut10 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_t & sel),
        .in_ready    (in_ready10),
        .binary_in   (bin_t),
        .out_valid   (out_valid10),
        .out_ready   (out_ready_t & sel),
        .bcd_out     (bcd10),
        .overflow    (ovf10),
        .digit_count (dcnt10),
        .busy        (busy10)
`ifdef SIGNED_INPUT_EN
        ,
        .neg_out     (neg10)
`endif
    );

`ifndef SIGNED_INPUT_EN
    assign neg8  = 1'b0;
    assign neg10 = 1'b0;
`endif

    logic        cur_in_ready, cur_out_valid, cur_busy, cur_ovf, cur_neg;
    logic [11:0] cur_bcd;
    logic [1:0]  cur_dcnt;
    assign cur_in_ready  = sel ? in_ready10  : in_ready8;
    assign cur_out_valid = sel ? out_valid10 : out_valid8;
    assign cur_busy      = sel ? busy10      : busy8;
    assign cur_ovf       = sel ? ovf10       : ovf8;
    assign cur_neg       = sel ? neg10       : neg8;
    assign cur_bcd       = sel ? bcd10       : bcd8;
    assign cur_dcnt      = sel ? dcnt10      : dcnt8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the (magnitude of the) input.
    function automatic exp_t model(input logic s, input logic [9:0] v);
        exp_t m;
        int   bw  = s ? 10 : 8;
        int   mag = s ? int'(v) : int'(v[7:0]);
        int   r;
        m.neg = 1'b0;
`ifdef SIGNED_INPUT_EN
        if (mag >= (1 << (bw - 1))) begin
            m.neg = 1'b1;
            mag   = (1 << bw) - mag;
        end
`endif
        m.ovf  = (mag >= 1000);
        r      = mag % 1000;
        m.bcd  = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
        m.dcnt = (r >= 100) ? 2'd3 : (r >= 10) ? 2'd2 : 2'd1;
        return m;
    endfunction

    task automatic accept(input logic s, input logic [9:0] v);
        int n = 0;
        sel        = s;
        bin_t      = v;
        in_valid_t = 1'b1;
        sb_q.push_back(model(s, v));
        while (!cur_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        in_valid_t = 1'b0;
    endtask

    task automatic finish_conv(input int hold, input logic junk);
        int          n   = 0;
        logic        bad = 1'b0;
        logic [11:0] snap;
        exp_t        e;
        if (junk) begin
            in_valid_t = 1'b1;
            bin_t      = ~bin_t;
        end
        while (!cur_out_valid && n < 200) begin
            if (cur_in_ready !== 1'b0 || cur_busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid_t = 1'b0;
        check("latency", 32'(n), sel ? 32'd10 : 32'd8);
        check("shift_in_ready_busy", 32'(bad), 32'd0);
        check("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("bcd_out", 32'(cur_bcd), 32'(e.bcd));
            check("overflow", 32'(cur_ovf), 32'(e.ovf));
            check("digit_count", 32'(cur_dcnt), 32'(e.dcnt));
            check("neg_out", 32'(cur_neg), 32'(e.neg));
            check("done_in_ready", 32'(cur_in_ready), 32'd0);
            snap = cur_bcd;
            bad  = 1'b0;
            if (hold > 0) begin
                repeat (hold) begin
                    @(posedge clk); #1;
                    if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0 ||
                        cur_busy !== 1'b0 || cur_bcd !== snap) bad = 1'b1;
                end
                check("hold_stable", 32'(bad), 32'd0);
            end
            out_ready_t = 1'b1;
            @(posedge clk); #1;
            out_ready_t = 1'b0;
            check("release_out_valid", 32'(cur_out_valid), 32'd0);
            check("release_in_ready", 32'(cur_in_ready), 32'd1);
            check("idle_bcd_kept", 32'(cur_bcd), 32'(e.bcd));
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_t  = 1'b0;
        out_ready_t = 1'b0;
        sel         = 1'b0;
        bin_t       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst8_in_ready", 32'(in_ready8), 32'd1);
        check("rst8_out_valid", 32'(out_valid8), 32'd0);
        check("rst8_bcd", 32'(bcd8), 32'd0);
        check("rst8_ovf", 32'(ovf8), 32'd0);
        check("rst8_dcnt", 32'(dcnt8), 32'd1);
        check("rst8_busy", 32'(busy8), 32'd0);
        check("rst8_neg", 32'(neg8), 32'd0);
        check("rst10_in_ready", 32'(in_ready10), 32'd1);
        check("rst10_out_valid", 32'(out_valid10), 32'd0);

        // Full-scale 8-bit value.
        accept(1'b0, 10'd255); finish_conv(0, 1'b0);
        // Zero then nine back to back; in_valid junk during SHIFT of the second.
        accept(1'b0, 10'd0);   finish_conv(0, 1'b0);
        accept(1'b0, 10'd9);   finish_conv(0, 1'b1);
        // Overflow boundary on the 10-bit instance.
        accept(1'b1, 10'd1000); finish_conv(0, 1'b0);
        accept(1'b1, 10'd999);  finish_conv(0, 1'b0);
        accept(1'b1, 10'd1023); finish_conv(0, 1'b0);
        // Backpressure: out_ready held low for 5 cycles.
        accept(1'b0, 10'd128); finish_conv(5, 1'b0);

        // Reset three cycles into SHIFT.
        accept(1'b0, 10'd77);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_in_ready", 32'(in_ready8), 32'd1);
        check("midrst_bcd", 32'(bcd8), 32'd0);
        check("midrst_dcnt", 32'(dcnt8), 32'd1);
        check("midrst_busy", 32'(busy8), 32'd0);
        accept(1'b0, 10'd42); finish_conv(0, 1'b0);

`ifdef SIGNED_INPUT_EN
        accept(1'b0, 10'h080); finish_conv(0, 1'b0);
        accept(1'b0, 10'h0FF); finish_conv(0, 1'b0);
`endif

        for (int i = 0; i < 5; i++) begin
            accept(1'b0, 10'($urandom_range(0, 255)));
            finish_conv(0, 1'b0);
            accept(1'b1, 10'($urandom_range(0, 1023)));
            finish_conv(i % 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
